prog_rom: RTL and testbench

Parametrised, field-reloadable program memory for the TD4 core. It replaces the fixed instruction table. After reset it presents a built-in default program on a combinational fetch port. A handshaked load port can overwrite the contents word by word while the CPU is held. It sits between the TD4 program counter/decoder and the board-level loader (UART or switch bank).

---
 rtl/prog_rom_pkg.sv | 40 ++++
 rtl/prog_rom_if.sv | 28 ++
 rtl/prog_rom_loader.sv | 134 +++++++++++++
 rtl/prog_rom.sv | 54 +++++
 tb/tb_prog_rom.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_rom_pkg.sv
// Shared types and the built-in default program for the TD4 reloadable program memory.
// Optional checksum trailer: define PROG_ROM_CHECKSUM_EN to add the CHECK and ERR states.
package prog_rom_pkg;

    localparam int IMG_W   = 8;
    localparam int IMG_LEN = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
`ifdef PROG_ROM_CHECKSUM_EN
        ST_CHECK = 3'd2,
        ST_ERR   = 3'd4,
`endif
        ST_DONE  = 3'd3
    } state_t;

    // Factory program. Only the first IMG_LEN words are meaningful; the rest are zero.
    function automatic logic [IMG_W-1:0] default_word(input int idx);
        logic [IMG_W-1:0] w;
        w = '0;
        if (idx < IMG_LEN) begin
            case (idx)
                0:       w = 8'hB3;
                1:       w = 8'hB6;
                2:       w = 8'hBC;
                3:       w = 8'hB8;
                4:       w = 8'hB8;
                5:       w = 8'hBC;
                6:       w = 8'hB6;
                7:       w = 8'hB3;
                8:       w = 8'hB1;
                9:       w = 8'hF0;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/prog_rom_if.sv
// Load port between the board-level loader (master) and prog_rom (slave).
interface prog_rom_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);

    // Handshake: a word moves on a rising clk edge where load_valid and load_ready are both
    // high. load_ready is a registered decode of the loader state and never depends on
    // load_valid; the source keeps load_data stable while load_valid is high until that edge.
    logic              load_start;
    logic [ADDR_W-1:0] load_len;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic              load_err;

    modport master (
        output load_start, load_len, load_valid, load_data,
        input  load_ready, load_done, load_err
    );

    modport slave (
        input  load_start, load_len, load_valid, load_data,
        output load_ready, load_done, load_err
    );

endinterface

// File: rtl/prog_rom_loader.sv
// Load-port FSM: tracks the write pointer, last address and running checksum, and turns
// accepted words into write strobes for the array. Checksum path under PROG_ROM_CHECKSUM_EN.
module prog_rom_loader
    import prog_rom_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    prog_rom_if.slave         bus,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              cpu_hold,
    output state_t            dbg_state,
    output logic [ADDR_W-1:0] dbg_ptr,
    output logic [ADDR_W-1:0] dbg_last
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W-1:0] last, last_n;
    logic              xfer;
    logic              ready_n;
    logic              hold_n;
    logic              done_n;
`ifdef PROG_ROM_CHECKSUM_EN
    logic [DATA_W-1:0] sum, sum_n;
    logic              err_n;
`endif

    assign xfer  = bus.load_valid && bus.load_ready;
    assign waddr = ptr;
    assign wdata = bus.load_data;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        last_n  = last;
        we      = 1'b0;
`ifdef PROG_ROM_CHECKSUM_EN
        sum_n   = sum;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_n = ST_LOAD;
                    ptr_n   = '0;
                    last_n  = bus.load_len;
`ifdef PROG_ROM_CHECKSUM_EN
                    sum_n   = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    we    = 1'b1;
                    ptr_n = ptr + 1'b1;
`ifdef PROG_ROM_CHECKSUM_EN
                    sum_n = sum + bus.load_data;
                    if (ptr == last) state_n = ST_CHECK;
`else
                    if (ptr == last) state_n = ST_DONE;
`endif
                end
            end
`ifdef PROG_ROM_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) state_n = (bus.load_data == sum) ? ST_DONE : ST_ERR;
            end
            // A failed image keeps the core frozen until the loader retries from scratch.
            ST_ERR: begin
                if (bus.load_start) begin
                    state_n = ST_LOAD;
                    ptr_n   = '0;
                    last_n  = bus.load_len;
                    sum_n   = '0;
                end
            end
`endif
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Handshake and status outputs are registered from the next state so they are glitch-free.
    always_comb begin
        ready_n = (state_n == ST_LOAD);
        hold_n  = (state_n != ST_IDLE);
        done_n  = (state_n == ST_DONE);
`ifdef PROG_ROM_CHECKSUM_EN
        ready_n = ready_n || (state_n == ST_CHECK);
        err_n   = (state_n == ST_ERR);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            last           <= '0;
            bus.load_ready <= 1'b0;
            bus.load_done  <= 1'b0;
            cpu_hold       <= 1'b0;
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            last           <= last_n;
            bus.load_ready <= ready_n;
            bus.load_done  <= done_n;
            cpu_hold       <= hold_n;
        end
    end

`ifdef PROG_ROM_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum          <= '0;
            bus.load_err <= 1'b0;
        end else begin
            sum          <= sum_n;
            bus.load_err <= err_n;
        end
    end
`else
    assign bus.load_err = 1'b0;
`endif

    assign dbg_state = state;
    assign dbg_ptr   = ptr;
    assign dbg_last  = last;

endmodule

// File: rtl/prog_rom.sv
// Field-reloadable TD4 program memory: register array with a reset-time default image,
// combinational fetch port and a handshaked load port. Checksum option: PROG_ROM_CHECKSUM_EN.
module prog_rom
    import prog_rom_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] qd,
    prog_rom_if.slave         bus,
    output logic              cpu_hold,
    output state_t            dbg_state,
    output logic [ADDR_W-1:0] dbg_ptr,
    output logic [ADDR_W-1:0] dbg_last
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    prog_rom_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .cpu_hold  (cpu_hold),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr),
        .dbg_last  (dbg_last)
    );

    // Reset restores the factory program, so an aborted load never leaves a partial image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(default_word(i));
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign qd = mem[addr];

endmodule

// File: tb/tb_prog_rom.sv
// Self-checking bench for prog_rom: randomized loads against an array model of the program.
module tb_prog_rom;
    import prog_rom_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] addr = '0;
    logic [7:0] qd;
    logic       cpu_hold;
    state_t     dbg_state;
    logic [3:0] dbg_ptr;
    logic [3:0] dbg_last;

    prog_rom_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    prog_rom #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .qd        (qd),
        .bus       (bus.slave),
        .cpu_hold  (cpu_hold),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr),
        .dbg_last  (dbg_last)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] dflt [16] = '{8'hB3, 8'hB6, 8'hBC, 8'hB8, 8'hB8, 8'hBC, 8'hB6, 8'hB3,
                              8'hB1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] model [16];
    logic [7:0] tx_q [$];
    int checks = 0;
    int errors = 0;
`ifdef PROG_ROM_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    function automatic logic [7:0] sum_of(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += tx_q[i];
        return 8'(s % 256);
    endfunction

    // Fill tx_q with n random payload words, plus the checksum trailer when enabled.
    task automatic make_payload(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
`ifdef PROG_ROM_CHECKSUM_EN
        tx_q.push_back(sum_of(n));
`endif
    endtask

    task automatic commit_model(input int n);
        for (int i = 0; i < n; i++) model[i] = tx_q[i];
    endtask

    // ---------------- driver ----------------
    task automatic drive_load(input logic [3:0] len, input int gap_pct,
                              output int done_pulses, output int done_at, output bit timed_out);
        int sent = 0;
        int n = 0;
        done_pulses = 0;
        done_at = -1;
        timed_out = 1'b0;
        @(negedge clk);
        bus.load_start = 1'b1;
        bus.load_len   = len;
        @(negedge clk);
        n = 1;
        bus.load_start = 1'b0;
        while (sent < tx_q.size() && n < 400) begin
            if (bus.load_done === 1'b1) begin
                done_pulses++;
                if (done_at < 0) done_at = n;
            end
            bus.load_valid = ($urandom_range(99) >= gap_pct);
            bus.load_data  = tx_q[sent];
            if (bus.load_valid && bus.load_ready === 1'b1) sent++;
            @(negedge clk);
            n++;
        end
        bus.load_valid = 1'b0;
        bus.load_data  = 8'($urandom);
        if (sent < tx_q.size()) timed_out = 1'b1;
        repeat (4) begin
            if (bus.load_done === 1'b1) begin
                done_pulses++;
                if (done_at < 0) done_at = n;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = dflt[i];
        @(negedge clk);
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold got %b exp 0", cpu_hold); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b exp 0", bus.load_ready); end
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b exp 0", bus.load_done); end
        checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b exp 0", bus.load_err); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
        checks++; if (dbg_ptr !== 4'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", dbg_ptr); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (qd !== model[a]) begin errors++; $display("FAIL reset_image addr=%0d got %h exp %h", a, qd, model[a]); end
        end
    endtask

    task automatic test_basic_load();
        int pulses, at;
        bit to;
        tx_q = '{8'h11, 8'h22, 8'h33};
`ifdef PROG_ROM_CHECKSUM_EN
        tx_q.push_back(8'h66);
`endif
        drive_load(4'd2, 0, pulses, at, to);
        commit_model(3);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got stalled exp all words accepted"); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", pulses); end
        checks++; if (at !== 4 + EXTRA) begin errors++; $display("FAIL basic_done_latency got %0d exp %0d", at, 4 + EXTRA); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL basic_cpu_hold got %b exp 0", cpu_hold); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (qd !== model[a]) begin errors++; $display("FAIL basic_qd addr=%0d got %h exp %h", a, qd, model[a]); end
        end
    endtask

    task automatic test_gaps();
        int pulses, at;
        bit to;
        make_payload(4);
        drive_load(4'd3, 50, pulses, at, to);
        commit_model(4);
        checks++; if (to) begin errors++; $display("FAIL gaps_timeout got stalled exp all words accepted"); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL gaps_done_pulses got %0d exp 1", pulses); end
        checks++; if (dbg_ptr !== 4'd4) begin errors++; $display("FAIL gaps_ptr got %0d exp 4", dbg_ptr); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (qd !== model[a]) begin errors++; $display("FAIL gaps_qd addr=%0d got %h exp %h", a, qd, model[a]); end
        end
    endtask

    task automatic test_full_load();
        int pulses, at;
        bit to;
        make_payload(16);
        drive_load(4'd15, 0, pulses, at, to);
        commit_model(16);
        checks++; if (to) begin errors++; $display("FAIL full_timeout got stalled exp all words accepted"); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL full_done_pulses got %0d exp 1", pulses); end
        checks++; if (at !== 17 + EXTRA) begin errors++; $display("FAIL full_done_latency got %0d exp %0d", at, 17 + EXTRA); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (qd !== model[a]) begin errors++; $display("FAIL full_qd addr=%0d got %h exp %h", a, qd, model[a]); end
        end
    endtask

    task automatic test_back_to_back();
        int pulses, at, len;
        bit to;
        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(15);
            make_payload(len + 1);
            drive_load(4'(len), 30, pulses, at, to);
            commit_model(len + 1);
            checks++; if (to) begin errors++; $display("FAIL b2b_timeout load=%0d got stalled exp accepted", k); end
            checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_done_pulses load=%0d got %0d exp 1", k, pulses); end
            checks++; if (dbg_last !== 4'(len)) begin errors++; $display("FAIL b2b_last load=%0d got %0d exp %0d", k, dbg_last, len); end
            for (int a = 0; a < 16; a++) begin
                addr = 4'(a); #1;
                checks++; if (qd !== model[a]) begin errors++; $display("FAIL b2b_qd load=%0d addr=%0d got %h exp %h", k, a, qd, model[a]); end
            end
        end
    endtask

    task automatic test_idle_valid();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.load_valid = 1'b1;
            bus.load_data  = 8'($urandom);
            checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", bus.load_ready); end
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL idle_state got %0d exp IDLE", dbg_state); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (qd !== model[a]) begin errors++; $display("FAIL idle_qd addr=%0d got %h exp %h", a, qd, model[a]); end
        end
    endtask

    task automatic test_start_in_load();
        make_payload(4);
        @(negedge clk); bus.load_start = 1'b1; bus.load_len = 4'd3;
        @(negedge clk); bus.load_start = 1'b0; bus.load_valid = 1'b1; bus.load_data = tx_q[0];
        @(negedge clk); bus.load_data = tx_q[1];
        @(negedge clk); bus.load_valid = 1'b0; bus.load_start = 1'b1; bus.load_len = 4'd0;
        @(negedge clk); bus.load_start = 1'b0;
        checks++; if (dbg_state !== ST_LOAD) begin errors++; $display("FAIL sil_state got %0d exp LOAD", dbg_state); end
        checks++; if (dbg_ptr !== 4'd2) begin errors++; $display("FAIL sil_ptr got %0d exp 2", dbg_ptr); end
        checks++; if (dbg_last !== 4'd3) begin errors++; $display("FAIL sil_last got %0d exp 3", dbg_last); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL sil_cpu_hold got %b exp 1", cpu_hold); end
        bus.load_valid = 1'b1; bus.load_data = tx_q[2];
        @(negedge clk); bus.load_data = tx_q[3];
`ifdef PROG_ROM_CHECKSUM_EN
        @(negedge clk); bus.load_data = tx_q[4];
`endif
        @(negedge clk); bus.load_valid = 1'b0;
        checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL sil_done got %b exp 1", bus.load_done); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL sil_hold_in_done got %b exp 1", cpu_hold); end
        @(negedge clk);
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL sil_done_width got %b exp 0", bus.load_done); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL sil_hold_release got %b exp 0", cpu_hold); end
        commit_model(4);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (qd !== model[a]) begin errors++; $display("FAIL sil_qd addr=%0d got %h exp %h", a, qd, model[a]); end
        end
    endtask

    task automatic test_reset_mid_load();
        make_payload(5);
        @(negedge clk); bus.load_start = 1'b1; bus.load_len = 4'd4;
        @(negedge clk); bus.load_start = 1'b0; bus.load_valid = 1'b1; bus.load_data = tx_q[0];
        @(negedge clk); bus.load_data = tx_q[1];
        @(negedge clk); bus.load_valid = 1'b0;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rml_hold_before got %b exp 1", cpu_hold); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) model[i] = dflt[i];
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rml_state got %0d exp IDLE", dbg_state); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rml_cpu_hold got %b exp 0", cpu_hold); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL rml_ready got %b exp 0", bus.load_ready); end
        checks++; if (dbg_ptr !== 4'd0) begin errors++; $display("FAIL rml_ptr got %0d exp 0", dbg_ptr); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (qd !== model[a]) begin errors++; $display("FAIL rml_qd addr=%0d got %h exp %h", a, qd, model[a]); end
        end
    endtask

`ifdef PROG_ROM_CHECKSUM_EN
    task automatic test_checksum();
        int pulses, at;
        bit to;
        tx_q = '{8'h11, 8'h22, 8'h34};
        drive_load(4'd1, 0, pulses, at, to);
        commit_model(2);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL cks_bad_done got %0d exp 0", pulses); end
        checks++; if (bus.load_err !== 1'b1) begin errors++; $display("FAIL cks_bad_err got %b exp 1", bus.load_err); end
        checks++; if (dbg_state !== ST_ERR) begin errors++; $display("FAIL cks_bad_state got %0d exp ERR", dbg_state); end
        repeat (3) begin
            @(negedge clk);
            bus.load_valid = 1'b1; bus.load_data = 8'h55;
            checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL cks_hold_stuck got %b exp 1", cpu_hold); end
            checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL cks_err_ready got %b exp 0", bus.load_ready); end
        end
        @(negedge clk); bus.load_valid = 1'b0;
        tx_q = '{8'h11, 8'h22, 8'h33};
        drive_load(4'd1, 20, pulses, at, to);
        checks++; if (to) begin errors++; $display("FAIL cks_good_timeout got stalled exp accepted"); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL cks_good_done got %0d exp 1", pulses); end
        checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL cks_good_err got %b exp 0", bus.load_err); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL cks_good_hold got %b exp 0", cpu_hold); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (qd !== model[a]) begin errors++; $display("FAIL cks_qd addr=%0d got %h exp %h", a, qd, model[a]); end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        test_reset();
        test_basic_load();
        test_gaps();
        test_idle_valid();
        test_full_load();
        test_start_in_load();
        test_back_to_back();
        test_reset_mid_load();
`ifdef PROG_ROM_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
